// File: rtl/matmul_sp_writer.sv
`default_nettype none
// ============================================================================
// Module      : matmul_sp_writer
// Description : Captures the one-cycle result burst from matmul_calc and
//               drains the (N+1)x(M+1) result words onto a valid/ready
//               scratchpad write port. Words go out one BUS_WIDTH word per
//               beat, to consecutive byte addresses of one selected target.
//               Optional feature macro: SP_WRITER_FLAGS_WORD_EN. When it is
//               defined, one extra beat carrying the overflow flags follows
//               the last result word.
// Revision    : 1.0 - initial release
// ============================================================================
module matmul_sp_writer #(
    parameter  int DATA_WIDTH  = 8,
    parameter  int BUS_WIDTH   = 32,
    parameter  int ADDR_WIDTH  = 16,
    parameter  int SP_NTARGETS = 2,
    localparam int MAX_DIM     = BUS_WIDTH / DATA_WIDTH,
    localparam int TSEL_W      = (SP_NTARGETS > 1) ? $clog2(SP_NTARGETS) : 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 sp_write_i,
    input  logic [BUS_WIDTH*MAX_DIM*MAX_DIM-1:0] write_to_sp_i,
    input  logic [MAX_DIM*MAX_DIM-1:0]           flags_i,
    input  logic [1:0]                           dimension_N_i,
    input  logic [1:0]                           dimension_M_i,
    input  logic [ADDR_WIDTH-1:0]                sp_base_addr_i,
    input  logic [TSEL_W-1:0]                    sp_target_i,
    output logic                                 sp_wr_valid_o,
    input  logic                                 sp_wr_ready_i,
    output logic [ADDR_WIDTH-1:0]                sp_wr_addr_o,
    output logic [BUS_WIDTH-1:0]                 sp_wr_data_o,
    output logic [SP_NTARGETS-1:0]               sp_wr_sel_o,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic [MAX_DIM*MAX_DIM-1:0]           flags_o,
    output logic                                 drop_o
);

    localparam int NWORDS = MAX_DIM * MAX_DIM;
    localparam int BYTES  = BUS_WIDTH / 8;
    localparam int IDX_W  = $clog2(NWORDS + 2);
`ifdef SP_WRITER_FLAGS_WORD_EN
    localparam int FLAG_BEATS = 1;
`else
    localparam int FLAG_BEATS = 0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                     state;
    logic [BUS_WIDTH*NWORDS-1:0] res_q;       // captured result words
    logic [IDX_W-1:0]           idx;          // index of the beat currently presented
    logic [IDX_W-1:0]           cnt_words;    // number of result words in the burst
    logic [IDX_W-1:0]           last_cnt;     // total beats including optional flags beat
    logic [IDX_W-1:0]           next_idx;
    logic [IDX_W-1:0]           cap_words;    // word count derived from incoming dims
    logic [BUS_WIDTH-1:0]       next_data;
    int                         n_eff;
    int                         m_eff;
`ifdef SP_WRITER_FLAGS_WORD_EN
    logic [BUS_WIDTH-1:0]       flag_word;
    assign flag_word = BUS_WIDTH'(flags_o);
`endif

    assign last_cnt = cnt_words + IDX_W'(FLAG_BEATS);
    assign next_idx = idx + IDX_W'(1);

    // Clamp dimensions, size the incoming burst and pick the data for the next beat
    always_comb begin
        n_eff     = (int'(dimension_N_i) > MAX_DIM - 1) ? MAX_DIM - 1 : int'(dimension_N_i);
        m_eff     = (int'(dimension_M_i) > MAX_DIM - 1) ? MAX_DIM - 1 : int'(dimension_M_i);
        cap_words = IDX_W'((n_eff + 1) * (m_eff + 1));
        next_data = '0;
        for (int w = 0; w < NWORDS; w++) begin
            if (next_idx == IDX_W'(w)) begin
                next_data = res_q[w*BUS_WIDTH +: BUS_WIDTH];
            end
        end
`ifdef SP_WRITER_FLAGS_WORD_EN
        if (next_idx == cnt_words) begin
            next_data = flag_word;
        end
`endif
    end

    // Capture/drain state machine with registered port outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            res_q         <= '0;
            idx           <= '0;
            cnt_words     <= '0;
            sp_wr_valid_o <= 1'b0;
            sp_wr_addr_o  <= '0;
            sp_wr_data_o  <= '0;
            sp_wr_sel_o   <= '0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            flags_o       <= '0;
            drop_o        <= 1'b0;
        end else begin
            done_o <= 1'b0;
            drop_o <= 1'b0;
            case (state)
                // DONE accepts a new burst exactly like IDLE so back-to-back bursts survive
                IDLE, DONE: begin
                    if (sp_write_i) begin
                        state         <= WRITE;
                        res_q         <= write_to_sp_i;
                        flags_o       <= flags_i;
                        cnt_words     <= cap_words;
                        idx           <= '0;
                        sp_wr_valid_o <= 1'b1;
                        busy_o        <= 1'b1;
                        sp_wr_addr_o  <= sp_base_addr_i;
                        sp_wr_data_o  <= write_to_sp_i[BUS_WIDTH-1:0];
                        sp_wr_sel_o   <= SP_NTARGETS'(1) << sp_target_i;
                    end else begin
                        state <= IDLE;
                    end
                end
                WRITE: begin
                    if (sp_write_i) begin
                        drop_o <= 1'b1;
                    end
                    if (sp_wr_valid_o && sp_wr_ready_i) begin
                        if (next_idx == last_cnt) begin
                            state         <= DONE;
                            sp_wr_valid_o <= 1'b0;
                            busy_o        <= 1'b0;
                            done_o        <= 1'b1;
                        end else begin
                            idx          <= next_idx;
                            sp_wr_addr_o <= sp_wr_addr_o + ADDR_WIDTH'(BYTES);
                            sp_wr_data_o <= next_data;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
